// File: rtl/rst_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rst_seq_pkg
// Description : Shared types and helpers for the reset sequencer.
//               Provides the sequencer state encoding and the width helper
//               for the domain index counter.
// Revision    : 1.0 - initial release
// ============================================================================
package rst_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  // Width needed to hold a domain index in the range 0..n.
  function automatic int idx_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_ff
// Description : STAGES-deep single-bit synchroniser with asynchronous
//               active-low clear to 0.
// Ports       : clk   - destination clock
//               rst_n - asynchronous active-low clear
//               d     - asynchronous input bit
//               q     - synchronised output (last flop of the chain)
// Revision    : 1.0 - initial release
// ============================================================================
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
    end
  end

  assign q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/rst_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rst_seq_ctrl
// Description : Reset sequencer. Qualifies the clock-wizard lock, holds all
//               domains in reset for HOLD_CYC cycles, then releases N_RST
//               active-low domain resets one at a time, STEP_CYC apart.
//               Re-sequences on loss of lock or on a software request.
// Ports       : clk          - sequencer clock
//               rst_n        - asynchronous active-low reset
//               locked       - clock-wizard lock (asynchronous)
//               soft_rst_req - one-cycle request to re-run the sequence
//               rst_n_out    - per-domain active-low resets (registered)
//               ready        - all domains out of reset (registered)
//               busy         - sequence in progress (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int N_RST       = 3,
  parameter int HOLD_CYC    = 16,
  parameter int STEP_CYC    = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             locked,
  input  logic             soft_rst_req,
  output logic [N_RST-1:0] rst_n_out,
  output logic             ready,
  output logic             busy
);

  localparam int                IDX_W       = idx_w(N_RST);
  localparam logic [CNT_W-1:0]  c_hold_last = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0]  c_step_last = CNT_W'(STEP_CYC - 1);
  localparam logic [IDX_W-1:0]  c_idx_last  = IDX_W'(N_RST - 1);

  logic             w_lk_s;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
  logic [IDX_W-1:0] r_idx,   w_idx_nxt;
  logic [N_RST-1:0] r_rst_n_out, w_rst_n_out_nxt;
  logic             r_ready, w_ready_nxt;
  logic             r_busy,  w_busy_nxt;
  logic [N_RST-1:0] w_rel_mask;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (locked),
    .q     (w_lk_s)
  );

  // One-hot select of the domain released at the end of the current step.
  always_comb begin
    w_rel_mask = '0;
    for (int k = 0; k < N_RST; k++) begin
      if (r_idx == IDX_W'(k)) w_rel_mask[k] = 1'b1;
    end
  end

  // Next-state and next-output logic. Outputs are computed one cycle early
  // and registered, so nothing combinational reaches the ports.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_idx_nxt       = r_idx;
    w_rst_n_out_nxt = r_rst_n_out;
    w_ready_nxt     = r_ready;
    w_busy_nxt      = r_busy;

    case (r_state)
      WAIT_LOCK: begin
        w_rst_n_out_nxt = '0;
        w_ready_nxt     = 1'b0;
        w_busy_nxt      = 1'b0;
        w_cnt_nxt       = '0;
        w_idx_nxt       = '0;
        if (w_lk_s) begin
          w_state_nxt = HOLD;
          w_busy_nxt  = 1'b1;
        end
      end

      HOLD: begin
        if (r_cnt == c_hold_last) begin
          w_rst_n_out_nxt[0] = 1'b1;
          w_cnt_nxt          = '0;
          if (N_RST == 1) begin
            w_state_nxt = RUN;
            w_ready_nxt = 1'b1;
            w_busy_nxt  = 1'b0;
          end else begin
            w_state_nxt = RELEASE;
            w_idx_nxt   = IDX_W'(1);
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      RELEASE: begin
        if (r_cnt == c_step_last) begin
          w_rst_n_out_nxt = r_rst_n_out | w_rel_mask;
          w_cnt_nxt       = '0;
          if (r_idx == c_idx_last) begin
            w_state_nxt = RUN;
            w_ready_nxt = 1'b1;
            w_busy_nxt  = 1'b0;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      RUN: begin
        if (soft_rst_req) begin
          w_state_nxt     = HOLD;
          w_rst_n_out_nxt = '0;
          w_ready_nxt     = 1'b0;
          w_busy_nxt      = 1'b1;
          w_cnt_nxt       = '0;
          w_idx_nxt       = '0;
        end
      end

      default: begin
        w_state_nxt = WAIT_LOCK;
      end
    endcase

    // Lock loss overrides everything, including a same-cycle soft request.
    if (!w_lk_s && (r_state != WAIT_LOCK)) begin
      w_state_nxt     = WAIT_LOCK;
      w_rst_n_out_nxt = '0;
      w_ready_nxt     = 1'b0;
      w_busy_nxt      = 1'b0;
      w_cnt_nxt       = '0;
      w_idx_nxt       = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= WAIT_LOCK;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_rst_n_out <= '0;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_idx       <= w_idx_nxt;
      r_rst_n_out <= w_rst_n_out_nxt;
      r_ready     <= w_ready_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign rst_n_out = r_rst_n_out;
  assign ready     = r_ready;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_rst_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rst_seq_ctrl
// Description : Self-checking bench for rst_seq_ctrl. Drives a default
//               instance (3 domains, 16/4 timing) and a corner instance
//               (1 domain, 1/1 timing) from shared inputs and compares both
//               against a timeline model: each sequence is tracked as the
//               number of cycles since HOLD entry, and every output follows
//               from that count by simple arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rst_seq_ctrl;

  localparam int A_N = 3, A_HOLD = 16, A_STEP = 4;
  localparam int B_N = 1, B_HOLD = 1,  B_STEP = 1;
  localparam int A_DONE = A_HOLD + (A_N - 1) * A_STEP;
  localparam int B_DONE = B_HOLD + (B_N - 1) * B_STEP;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       locked;
  logic       soft_rst_req;
  logic [2:0] rst_a;
  logic       ready_a, busy_a;
  logic [0:0] rst_b;
  logic       ready_b, busy_b;

  int checks   = 0;
  int failures = 0;

  // Model state: cycles since HOLD entry (-1 = waiting for lock) and a
  // copy of the lock synchroniser pipeline.
  int         t_a, t_b;
  logic [1:0] pipe_a, pipe_b;

  always #5 clk = ~clk;

  rst_seq_ctrl #(
    .SYNC_STAGES(2), .N_RST(A_N), .HOLD_CYC(A_HOLD), .STEP_CYC(A_STEP), .CNT_W(8)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .locked(locked), .soft_rst_req(soft_rst_req),
    .rst_n_out(rst_a), .ready(ready_a), .busy(busy_a)
  );

  rst_seq_ctrl #(
    .SYNC_STAGES(2), .N_RST(B_N), .HOLD_CYC(B_HOLD), .STEP_CYC(B_STEP), .CNT_W(4)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .locked(locked), .soft_rst_req(soft_rst_req),
    .rst_n_out(rst_b), .ready(ready_b), .busy(busy_b)
  );

  function automatic logic [7:0] exp_rst(input int t, input int n, input int hold, input int step);
    logic [7:0] v;
    v = '0;
    for (int k = 0; k < n; k++) begin
      if (t >= 0 && t >= hold + k * step) v[k] = 1'b1;
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one sequence timeline by one clock edge using pre-edge inputs.
  task automatic adv(inout int t, inout logic [1:0] pipe, input int tdone);
    logic lks;
    lks = pipe[1];
    if (t < 0) begin
      if (lks) t = 0;
    end else if (!lks) begin
      t = -1;
    end else if (t >= tdone && soft_rst_req) begin
      t = 0;
    end else if (t < tdone) begin
      t = t + 1;
    end
    pipe = {pipe[0], locked};
  endtask

  task automatic check_all();
    logic [7:0] e;
    logic [7:0] r;
    e = exp_rst(t_a, A_N, A_HOLD, A_STEP);
    chk("a_rst_n_out", {5'b0, rst_a}, e);
    chk("a_ready", {7'b0, ready_a}, {7'b0, (t_a >= A_DONE)});
    chk("a_busy",  {7'b0, busy_a},  {7'b0, (t_a >= 0 && t_a < A_DONE)});
    r = {5'b0, rst_a};
    chk("a_monotonic", {7'b0, ((r & (r + 8'd1)) == 8'd0)}, 8'd1);
    e = exp_rst(t_b, B_N, B_HOLD, B_STEP);
    chk("b_rst_n_out", {7'b0, rst_b}, e);
    chk("b_ready", {7'b0, ready_b}, {7'b0, (t_b >= B_DONE)});
    chk("b_busy",  {7'b0, busy_b},  {7'b0, (t_b >= 0 && t_b < B_DONE)});
  endtask

  task automatic step();
    if (!rst_n) begin
      t_a = -1; pipe_a = '0;
      t_b = -1; pipe_b = '0;
    end else begin
      adv(t_a, pipe_a, A_DONE);
      adv(t_b, pipe_b, B_DONE);
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int lat;
    int r;
    rst_n = 1'b0; locked = 1'b0; soft_rst_req = 1'b0;
    t_a = -1; t_b = -1; pipe_a = '0; pipe_b = '0;

    // Reset state, then idle without lock.
    steps(3);
    rst_n = 1'b1;
    steps(4);

    // Lock rises: HOLD entry latency, then full staggered release.
    locked = 1'b1;
    lat = 0;
    for (int i = 0; i < 10 && !busy_a; i++) begin
      step();
      lat++;
    end
    chk("hold_entry_latency", 8'(lat), 8'd3);
    steps(30);

    // Software re-sequence from RUN.
    soft_rst_req = 1'b1;
    step();
    soft_rst_req = 1'b0;
    chk("soft_rst_busy", {7'b0, busy_a}, 8'd1);
    steps(30);

    // Lock loss while in RELEASE, then re-lock.
    soft_rst_req = 1'b1;
    step();
    soft_rst_req = 1'b0;
    steps(17);
    locked = 1'b0;
    steps(5);
    locked = 1'b1;
    steps(35);

    // Lock loss and soft request in the same cycle: lock loss wins.
    locked = 1'b0;
    steps(2);
    soft_rst_req = 1'b1;
    step();
    soft_rst_req = 1'b0;
    chk("lockloss_beats_soft", {7'b0, busy_a}, 8'd0);
    steps(5);

    // Soft request during HOLD is ignored.
    locked = 1'b1;
    steps(8);
    soft_rst_req = 1'b1;
    step();
    soft_rst_req = 1'b0;
    steps(30);

    // Asynchronous reset mid-RELEASE, checked before the next clock edge.
    soft_rst_req = 1'b1;
    step();
    soft_rst_req = 1'b0;
    steps(17);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_n_out", {5'b0, rst_a}, 8'd0);
    chk("async_ready", {7'b0, ready_a}, 8'd0);
    chk("async_busy", {7'b0, busy_a}, 8'd0);
    chk("async_b_rst_n_out", {7'b0, rst_b}, 8'd0);
    steps(2);
    rst_n = 1'b1;
    steps(40);

    // Randomised traffic on lock, soft requests and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 99));
      soft_rst_req = (r < 10);
      if (!locked && r < 30) locked = 1'b1;
      else if (locked && r >= 97) locked = 1'b0;
      rst_n = ($urandom_range(0, 299) != 0);
      step();
    end
    rst_n = 1'b1;
    soft_rst_req = 1'b0;
    steps(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
